down_counter_3bit: RTL and testbench
====================================

Name: down_counter_3bit

Overview:
- Synchronous 3-bit down counter with parallel load. Decrements by one every clock edge and wraps from 0 to 7.
- Provides a zero-flag and a one-cycle wrap strobe for downstream timers and sequencers.
- Single clock domain.

Parameters:
- WIDTH, 3, counter width in bits. The spec values below assume 3; all arithmetic is modulo 2^WIDTH.
- RESET_VAL, 0, value loaded into q on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- d  input  WIDTH  parallel load value.
- load_en  input  1  when high, q takes d on the next edge instead of decrementing.
- q  output  WIDTH  current count, registered.
- zero  output  1  high while q == 0; combinational decode of registered q.
- wrap  output  1  registered one-cycle pulse, high in the cycle after q decremented 0 -> max.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (reset_n): evaluated only at a rising clk edge, with no asynchronous path.
- Priority at each rising edge: reset_n low > load_en high > decrement.
- Reset: q = RESET_VAL (0), wrap = 0, zero = 1. Reset overrides load_en and d; for example, load_en = 1 with d = 7 during reset still gives q = 0.
- Load: q <= d, wrap <= 0. A load takes effect on the same edge load_en is sampled high, so q is visible one cycle later. Holding load_en high keeps reloading d every cycle; q tracks d with one-cycle latency.
- Decrement: q <= q - 1 modulo 8, so the sequence is 7, 6, 5, 4, 3, 2, 1, 0, 7, ...
- wrap <= 1 only when a decrement takes q from 0 to 7; otherwise wrap <= 0.
- Counting is free-running; there is no separate enable. The counter decrements every cycle that is neither a reset nor a load.
- Reset mid-count: the next edge forces q = 0 regardless of the current value. Counting resumes on the first edge with reset_n high: 0 -> 7, and wrap pulses.
- Load of 0: q = 0 with no wrap pulse; the next decrement gives 7 and pulses wrap.
- Before the first reset edge, q is undefined. Verification starts checking after the first reset edge.
- All outputs are glitch-free relative to clk. zero is derived only from registered q.

Optional Feature:
- Macro: DOWNCNT_SATURATE_EN.
- Defined: the counter saturates at 0. A decrement at q == 0 holds q = 0, and wrap stays permanently 0. Load and reset are unchanged, so a load is needed to restart counting.
- Not defined (default): modulo wrap as above, and wrap pulses on each 0 -> 7 transition.

Test Plan:
- Reset with load: reset_n = 0, load_en = 1, d = 7 for 1 edge -> q = 0, zero = 1, wrap = 0 (reset beats load).
- Free run after reset: release reset_n and load_en -> q sequence over successive edges is 7, 6, 5, 4, 3, 2, 1, 0, 7. wrap = 1 only in the cycle q first reads 7, and again at the second 7. zero = 1 only while q = 0.
- Load mid-count: at q = 4, pulse load_en with d = 2 -> next q = 2, then 1, 0, 7. No wrap on the load edge; wrap on the 0 -> 7 edge.
- Continuous load: load_en held high, d stepping 5, 3 -> q follows d one cycle late; no decrement, wrap = 0.
- Reset mid-count: at q = 5, reset_n = 0 for 1 edge -> q = 0. After release, q = 7 with wrap = 1.
- DOWNCNT_SATURATE_EN build: from a load of 2 -> q = 1, 0, 0, 0; wrap never asserts. A load of 6 restarts counting at 6, 5, ...

Source files
------------

// File: rtl/down_counter_3bit.sv
// down_counter_3bit: free-running down counter with parallel load, zero flag and wrap strobe.
// Define DOWNCNT_SATURATE_EN to make the counter stop at 0 instead of wrapping.
module down_counter_3bit #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_en,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             wrap
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             w_at_zero;

    assign w_at_zero = r_q == '0;

    always_comb begin
`ifdef DOWNCNT_SATURATE_EN
        w_q_nxt    = w_at_zero ? '0 : r_q - 1'b1;
        w_wrap_nxt = 1'b0;
`else
        w_q_nxt    = r_q - 1'b1;
        w_wrap_nxt = w_at_zero;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else if (load_en) begin
            r_q    <= d;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign q    = r_q;
    assign zero = w_at_zero;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_down_counter_3bit.sv
// tb_down_counter_3bit: directed vector table plus randomized run against a reference model.
module tb_down_counter_3bit;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] d = '0;
    logic [2:0] q;
    logic       zero;
    logic       wrap;
    int         checks = 0;
    int         failures = 0;
    int         m_q = 0;
    int         m_w = 0;

    typedef struct packed {
        logic       r;
        logic       l;
        logic [2:0] d;
        logic [2:0] q;
        logic       z;
        logic       w;
    } vec_t;

    vec_t tbl[$];

    down_counter_3bit dut (
        .clk(clk), .reset_n(reset_n), .d(d), .load_en(load_en),
        .q(q), .zero(zero), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic l, input logic [2:0] dv);
        @(negedge clk);
        reset_n = r;
        load_en = l;
        d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input int ez, input int ew);
        check({tag, ".q"}, int'(q), eq);
        check({tag, ".zero"}, int'(zero), ez);
        check({tag, ".wrap"}, int'(wrap), ew);
    endtask

    // Behavioural model: count value as an integer, wrap/saturate from the stated rules.
    task automatic model_step(input logic r, input logic l, input logic [2:0] dv);
        if (!r) begin
            m_q = 0;
            m_w = 0;
        end else if (l) begin
            m_q = int'(dv);
            m_w = 0;
        end else begin
`ifdef DOWNCNT_SATURATE_EN
            m_w = 0;
            m_q = (m_q > 0) ? m_q - 1 : 0;
`else
            m_w = (m_q == 0) ? 1 : 0;
            m_q = (m_q + 7) % 8;
`endif
        end
    endtask

    initial begin
        logic r, l;
        logic [2:0] dv;
        repeat (2) @(posedge clk);
`ifndef DOWNCNT_SATURATE_EN
        tbl.push_back('{1'b0, 1'b1, 3'd7, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 3'd6, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].l, tbl[i].d);
            check_all($sformatf("vec%0d", i), int'(tbl[i].q), int'(tbl[i].z), int'(tbl[i].w));
        end
`else
        apply(1'b0, 1'b1, 3'd7);
        check_all("sat_reset", 0, 1, 0);
        apply(1'b1, 1'b1, 3'd2);
        check_all("sat_load2", 2, 0, 0);
        apply(1'b1, 1'b0, 3'd0);
        check_all("sat_1", 1, 0, 0);
        apply(1'b1, 1'b0, 3'd0);
        check_all("sat_0a", 0, 1, 0);
        apply(1'b1, 1'b0, 3'd0);
        check_all("sat_0b", 0, 1, 0);
        apply(1'b1, 1'b0, 3'd0);
        check_all("sat_0c", 0, 1, 0);
        apply(1'b1, 1'b1, 3'd6);
        check_all("sat_load6", 6, 0, 0);
        apply(1'b1, 1'b0, 3'd0);
        check_all("sat_5", 5, 0, 0);
`endif
        apply(1'b0, 1'b0, 3'd0);
        model_step(1'b0, 1'b0, 3'd0);
        check_all("rnd_reset", m_q, (m_q == 0) ? 1 : 0, m_w);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(15) != 0);
            l  = ($urandom_range(4) == 0);
            dv = 3'($urandom_range(7));
            apply(r, l, dv);
            model_step(r, l, dv);
            check_all($sformatf("rnd%0d", i), m_q, (m_q == 0) ? 1 : 0, m_w);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
